// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between the
// instruction-fetch port (I, read-only) and the load/store port (D).
// One transaction at a time: IDLE -> ISSUE -> [WAIT] -> ACK -> IDLE.
// D has priority. After STARVE_MAX consecutive D grants while I is waiting,
// the next contested grant goes to I.
// Ports:
//   clk, resetn             clock; asynchronous reset, active-high
//   i_req/i_addr            fetch request and address
//   i_ack/i_rdata           fetch done pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request (load or store)
//   d_ack/d_rdata           data done pulse and load data
//   m_en/m_we/m_addr/m_wdata   memory strobe and command (zero when idle)
//   m_rdata                 memory read data, MEM_LAT cycles after m_en
//   busy                    high whenever the FSM is not in IDLE
//   grant_d                 owner of the current/last transaction (1 = D)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              grant_d
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_END = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t             state, state_nx;
  logic               own_d, own_we;
  logic [LAT_W-1:0]   lat_cnt;
  logic [STV_W-1:0]   starve_cnt;
  logic               grant_c, pick_d_c, capture_c, to_ack_c;

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and per-cycle decisions
  always_comb begin
    state_nx  = state;
    grant_c   = 1'b0;
    pick_d_c  = 1'b0;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_c  = 1'b1;
          // D wins a contested grant unless fetch has waited long enough
          pick_d_c = d_req && !(i_req && (starve_cnt == STV_END));
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = own_we ? ACK : WAIT;
      WAIT: begin
        if (lat_cnt == LAT_END) begin
          capture_c = 1'b1;
          state_nx  = ACK;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    to_ack_c = (state_nx == ACK);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      own_d      <= 1'b0;
      own_we     <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      busy       <= 1'b0;
      grant_d    <= 1'b0;
    end else begin
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= to_ack_c && !own_d;
      d_ack   <= to_ack_c && own_d;
      busy    <= (state_nx != IDLE);

      // The memory command registers double as the latched transaction
      if (grant_c) begin
        own_d   <= pick_d_c;
        own_we  <= pick_d_c && d_we;
        grant_d <= pick_d_c;
        m_en    <= 1'b1;
        m_we    <= pick_d_c && d_we;
        m_addr  <= pick_d_c ? d_addr : i_addr;
        m_wdata <= pick_d_c ? d_wdata : '0;
        if (!pick_d_c)
          starve_cnt <= '0;
        else if (i_req && (starve_cnt != STV_END))
          starve_cnt <= starve_cnt + STV_W'(1);
      end

      if (state == ISSUE)
        lat_cnt <= own_we ? '0 : LAT_W'(1);
      else if (state == WAIT)
        lat_cnt <= capture_c ? '0 : lat_cnt + LAT_W'(1);

      if (capture_c) begin
        if (own_d) d_rdata <= m_rdata;
        else       i_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner
// sequences, latency sweep on two extra instances, then random traffic
// against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;
  localparam int          STV = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, i_ack, d_req, d_we, d_ack;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic        m_en, m_we, busy, grant_d;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {16'h2002, a[15:0] + 16'd1};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(STV)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy), .grant_d(grant_d)
  );

  // Memory model: synchronous write, read data MEM_LAT cycles after m_en
  logic [31:0] mem [256];
  logic [31:0] pipe [LAT];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= mem_init(32'(i));
    else if (m_en && m_we) mem[m_addr[7:0]] <= m_wdata;
    pipe[0] <= mem[m_addr[7:0]];
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign m_rdata = pipe[LAT-1];

  // Latency-sweep instances (MEM_LAT 1 and 7), fetch port only
  logic        s_req [2];
  logic        s_iack [2], s_dack [2], s_men [2], s_mwe [2], s_busy [2], s_gd [2];
  logic [31:0] s_irdata [2], s_drdata [2], s_maddr [2], s_mwdata [2], s_mrdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int SL = (g == 0) ? 1 : 7;
    logic [31:0] sp [SL];
    always @(posedge clk) begin
      sp[0] <= mem_init(s_maddr[g]);
      for (int k = 1; k < SL; k++) sp[k] <= sp[k-1];
    end
    assign s_mrdata[g] = sp[SL-1];
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(SL), .STARVE_MAX(STV)) u_dut (
      .clk(clk), .resetn(resetn),
      .i_req(s_req[g]), .i_addr(32'h0000_000C), .i_ack(s_iack[g]), .i_rdata(s_irdata[g]),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_ack(s_dack[g]), .d_rdata(s_drdata[g]),
      .m_en(s_men[g]), .m_we(s_mwe[g]), .m_addr(s_maddr[g]), .m_wdata(s_mwdata[g]),
      .m_rdata(s_mrdata[g]), .busy(s_busy[g]), .grant_d(s_gd[g])
    );
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_ack;
  } vec_t;

  vec_t        vecs [5];
  int          men_c, ack_c, ic, dc, n_g, acks, busy_err, sa [2];
  logic [31:0] men_a, men_d, got, ir, dr, sr [2];
  logic        men_w, wrong, ovl, done;
  logic [7:0]  ord;

  // Reference model state
  logic [31:0] ref_mem [256];
  int          free, cnt, exp_men, exp_ack, exp_start;
  logic        exp_d, exp_we, started, pd;
  logic [31:0] exp_addr, exp_wd, exp_rd;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h04, 32'h0,         32'h2002_0005, 4};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0,         2};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 4};
    vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 4};
    vecs[4] = '{1'b1, 1'b0, 32'h08, 32'h0,         32'h2002_0009, 4};

    resetn = 1'b1; mem_clr = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    s_req[0] = 1'b0; s_req[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({i_ack, d_ack, m_en, m_we, busy, grant_d}), 64'(0));
    chk("reset_data", 64'({|m_addr, |m_wdata, |i_rdata, |d_rdata}), 64'(0));
    mem_clr = 1'b0; resetn = 1'b0;
    @(negedge clk);

    // Directed single transactions from IDLE
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].is_d) begin
        d_req = 1'b1; d_we = vecs[v].we; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      end else begin
        i_req = 1'b1; i_addr = vecs[v].addr;
      end
      men_c = -1; ack_c = -1; wrong = 1'b0; got = '0;
      men_a = '0; men_w = 1'b0; men_d = '0;
      for (int t = 1; t <= 20 && ack_c < 0; t++) begin
        @(negedge clk);
        if (m_en && men_c < 0) begin men_c = t; men_a = m_addr; men_w = m_we; men_d = m_wdata; end
        if (vecs[v].is_d ? i_ack : d_ack) wrong = 1'b1;
        if (vecs[v].is_d ? d_ack : i_ack) begin
          ack_c = t; got = vecs[v].is_d ? d_rdata : i_rdata;
          i_req = 1'b0; d_req = 1'b0;
        end
      end
      i_req = 1'b0; d_req = 1'b0;
      chk($sformatf("v%0d_men_cycle", v), 64'(men_c), 64'(1));
      chk($sformatf("v%0d_m_addr", v), 64'(men_a), 64'(vecs[v].addr));
      chk($sformatf("v%0d_m_we", v), 64'(men_w), 64'(vecs[v].we));
      if (vecs[v].we) chk($sformatf("v%0d_m_wdata", v), 64'(men_d), 64'(vecs[v].wdata));
      chk($sformatf("v%0d_ack_cycle", v), 64'(ack_c), 64'(vecs[v].exp_ack));
      if (!vecs[v].we) chk($sformatf("v%0d_rdata", v), 64'(got), 64'(vecs[v].exp_rdata));
      chk($sformatf("v%0d_wrong_ack", v), 64'(wrong), 64'(0));
      @(negedge clk);
    end

    // Simultaneous requests: D first, then I, acks never overlap
    i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    n_g = 0; ord = '0; ic = -1; dc = -1; ovl = 1'b0; ir = '0; dr = '0;
    for (int t = 1; t <= 30 && (ic < 0 || dc < 0); t++) begin
      @(negedge clk);
      if (m_en) begin ord = {ord[6:0], grant_d}; n_g++; end
      if (i_ack && d_ack) ovl = 1'b1;
      if (d_ack && dc < 0) begin dc = t; dr = d_rdata; d_req = 1'b0; end
      if (i_ack && ic < 0) begin ic = t; ir = i_rdata; i_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("sim_grants", 64'(n_g), 64'(2));
    chk("sim_order", 64'(ord[1:0]), 64'(2'b10));
    chk("sim_d_ack_cycle", 64'(dc), 64'(4));
    chk("sim_i_ack_cycle", 64'(ic), 64'(9));
    chk("sim_overlap", 64'(ovl), 64'(0));
    chk("sim_d_rdata", 64'(dr), 64'(32'h2002_0041));
    chk("sim_i_rdata", 64'(ir), 64'(32'h2002_0031));
    @(negedge clk);

    // Starvation guard: I held, D always pending -> D,D,D,I,D,D,D,I
    i_req = 1'b1; i_addr = 32'h50; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'h1111;
    n_g = 0; ord = '0; done = 1'b0;
    for (int t = 1; t <= 200 && !done; t++) begin
      @(negedge clk);
      if (m_en && n_g < 8) begin ord = {ord[6:0], grant_d}; n_g++; end
      if (n_g == 8 && i_ack) begin i_req = 1'b0; d_req = 1'b0; done = 1'b1; end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("starve_grants", 64'(n_g), 64'(8));
    chk("starve_order", 64'(ord), 64'(8'hEE));
    repeat (12) @(negedge clk);

    // Reset in the middle of a read's WAIT
    i_req = 1'b1; i_addr = 32'h10;
    repeat (2) @(negedge clk);
    resetn = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctrl", 64'({i_ack, d_ack, m_en, m_we, busy, grant_d}), 64'(0));
    chk("rst_mid_data", 64'({|m_addr, |m_wdata, |i_rdata, |d_rdata}), 64'(0));
    resetn = 1'b0; acks = 0;
    repeat (15) begin
      @(negedge clk);
      if (i_ack || d_ack || m_en || busy) acks++;
    end
    chk("rst_no_ack", 64'(acks), 64'(0));

    // Latency sweep: MEM_LAT 1 -> ack cycle 3, MEM_LAT 7 -> ack cycle 9
    busy_err = 0; sa[0] = -1; sa[1] = -1; sr[0] = '0; sr[1] = '0;
    if (s_busy[0] || s_busy[1]) busy_err++;
    s_req[0] = 1'b1; s_req[1] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (s_busy[g] !== (t <= ((g == 0) ? 3 : 9))) busy_err++;
        if (s_iack[g] && sa[g] < 0) begin sa[g] = t; sr[g] = s_irdata[g]; s_req[g] = 1'b0; end
      end
    end
    s_req[0] = 1'b0; s_req[1] = 1'b0;
    chk("sweep_lat1_ack", 64'(sa[0]), 64'(3));
    chk("sweep_lat7_ack", 64'(sa[1]), 64'(9));
    chk("sweep_lat1_rdata", 64'(sr[0]), 64'(32'h2002_000D));
    chk("sweep_lat7_rdata", 64'(sr[1]), 64'(32'h2002_000D));
    chk("sweep_busy", 64'(busy_err), 64'(0));

    // Random traffic against a transaction-level model
    resetn = 1'b1; mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0; resetn = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(32'(i));
    free = 0; cnt = 0; exp_men = -10; exp_ack = -10; exp_start = -10; started = 1'b0;
    exp_d = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0; exp_rd = '0;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      if (t == exp_men) begin
        chk("r_m_en", 64'(m_en), 64'(1));
        chk("r_m_addr", 64'(m_addr), 64'(exp_addr));
        chk("r_m_we", 64'(m_we), 64'(exp_we));
        if (exp_we) chk("r_m_wdata", 64'(m_wdata), 64'(exp_wd));
      end else begin
        chk("r_bus_idle", 64'({m_en, m_we, |m_addr, |m_wdata}), 64'(0));
      end
      chk("r_i_ack", 64'(i_ack), 64'(t == exp_ack && !exp_d));
      chk("r_d_ack", 64'(d_ack), 64'(t == exp_ack && exp_d));
      if (t == exp_ack && !exp_we)
        chk("r_rdata", 64'(exp_d ? d_rdata : i_rdata), 64'(exp_rd));
      chk("r_busy", 64'(busy), 64'(t > exp_start && t <= exp_ack));
      if (started) chk("r_grant_d", 64'(grant_d), 64'(exp_d));

      // Requesters: drop or renew on ack, otherwise occasionally raise
      if (i_ack) begin
        i_req = 1'($urandom_range(0, 1)); i_addr = 32'($urandom_range(0, 255));
      end else if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = 32'($urandom_range(0, 255));
      end
      if (d_ack) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 255)); d_wdata = $urandom;
      end else if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 255)); d_wdata = $urandom;
      end

      // Model: arbiter is free to decide once per transaction
      if (t == free) begin
        if (i_req || d_req) begin
          pd = d_req && !(i_req && cnt == STV);
          if (!pd) cnt = 0;
          else if (i_req && cnt < STV) cnt++;
          started   = 1'b1;
          exp_start = t;
          exp_men   = t + 1;
          exp_d     = pd;
          exp_we    = pd && d_we;
          exp_addr  = pd ? d_addr : i_addr;
          exp_wd    = d_wdata;
          if (exp_we) ref_mem[exp_addr[7:0]] = d_wdata;
          else        exp_rd = ref_mem[exp_addr[7:0]];
          exp_ack   = t + 2 + (exp_we ? 0 : int'(LAT));
          free      = exp_ack + 1;
        end else begin
          free = t + 1;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the CPU instruction-fetch port (I) and the load/store data port (D).
- Sits between the pipeline's IF/MEM stages and the unified memory array.
- Serialises requests through a 4-state FSM, with data-side priority plus a starvation guard for fetch.
- Returns read data with a one-cycle acknowledge pulse per transaction.

Parameters:
ADDR_W, 32, address width of both ports and the memory
DATA_W, 32, data word width
MEM_LAT, 2, memory read latency in cycles from m_en to m_rdata valid (legal 1..7)
STARVE_MAX, 3, consecutive D grants allowed while I is pending before I is forced

Ports:
clk  input  1  system clock; all logic on rising edge
resetn  input  1  asynchronous reset, active-high (1 = reset asserted)
i_req  input  1  fetch request; held high until i_ack
i_addr  input  ADDR_W  fetch address; stable while i_req high
i_ack  output  1  one-cycle pulse; fetch complete, i_rdata valid
i_rdata  output  DATA_W  fetched word; valid only in the i_ack cycle
d_req  input  1  data request; held high until d_ack
d_we  input  1  1 = store, 0 = load; stable while d_req high
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_ack  output  1  one-cycle pulse; data transaction complete
d_rdata  output  DATA_W  load data; valid only in the d_ack cycle
m_en  output  1  memory access strobe, one cycle per transaction
m_we  output  1  memory write enable, qualified by m_en
m_addr  output  ADDR_W  memory address
m_wdata  output  DATA_W  memory write data
m_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after the m_en cycle
busy  output  1  high in every state except IDLE
grant_d  output  1  owner of the current/last transaction (1 = D, 0 = I)

Behaviour:
- Reset (async, resetn=1): state=IDLE; all outputs 0; starve_cnt=0; lat_cnt=0. Any in-flight transaction is dropped; no ack is issued for it.
- All outputs are registered; no combinational input-to-output path.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: sample i_req/d_req.
  - Neither: stay.
  - Only one: grant it.
  - Both: grant D, unless starve_cnt==STARVE_MAX, then grant I.
  - On grant, latch owner/we/addr/wdata; go to ISSUE.
- ISSUE (1 cycle): m_en=1, m_addr, m_we, m_wdata driven from latched values.
  - Write: go to ACK.
  - Read: lat_cnt=1; go to WAIT.
- WAIT: lat_cnt increments each cycle. When lat_cnt==MEM_LAT, capture m_rdata into the owner's rdata register and go to ACK.
- ACK (1 cycle): owner's ack=1; go to IDLE. Requests are not sampled in ACK, so the requester has one cycle to drop or renew req.
- Latency, with request first seen high in cycle 0:
  - m_en in cycle 1.
  - Read ack in cycle 2+MEM_LAT.
  - Write ack in cycle 2.
  - Back-to-back transactions start every 3+MEM_LAT cycles (reads) or 3 cycles (writes).
- I-port accesses are always reads (m_we=0).
- starve_cnt update at each grant:
  - D granted while i_req=1: increment, saturating at STARVE_MAX.
  - I granted: clear to 0.
  - D granted with i_req=0: unchanged.
- Outside their ack cycles, i_rdata/d_rdata hold their last value and are don't-care.
- m_addr, m_wdata and m_we are 0 whenever m_en=0.
- Requester dropping req before its ack (protocol violation): the latched transaction still completes and acks.
- A req rising during ACK is first seen in the following IDLE cycle.

Test Plan:
- Reset: resetn=1 mid-WAIT of a read at 0x10 -> next edge all outputs 0, busy=0; after release, no i_ack/d_ack for the dropped read.
- Single fetch: i_req=1, i_addr=0x04, memory returns 0x2002_0005 (MEM_LAT=2) -> m_en in cycle 1 with m_addr=0x04, m_we=0; i_ack with i_rdata=0x2002_0005 in cycle 4.
- Store then load: d_we=1, d_addr=0x20, d_wdata=0xDEAD_BEEF -> m_en+m_we in cycle 1, d_ack in cycle 2; then load 0x20 -> d_rdata=0xDEAD_BEEF at its d_ack.
- Simultaneous requests: i_req and d_req both high in cycle 0 -> D granted first (grant_d=1), I granted in the next IDLE; acks never overlap.
- Starvation: i_req held high, d_req re-asserted after every d_ack, STARVE_MAX=3 -> grant order D,D,D,I; starve_cnt returns to 0 after the I grant.
- Latency sweep: MEM_LAT=1 and 7 -> read ack in cycle 3 and cycle 9 respectively; busy high from cycle 1 through the ack cycle.
